dmem_pulse_responder: RTL

DMEM_PULSE_RESPONDER -- requirements
Module: dmem_pulse_responder

---
 rtl/dmem_pulse_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_pulse_responder.sv
// dmem_pulse_responder: a pulse-driven data memory that sits behind the EXU/MEM stage.
// Latency: the response comes LATENCY cycles after the request pulse. A combined
// read+write pulse answers the write first; the read follows one idle cycle later.
// Busy/backpressure: busy is raised from the request pulse until the response cycle.
// A pulse that arrives while an access is in flight is dropped and sets the sticky
// overlap_err flag.
// Ports: clk, rst (synchronous, active-high); MEM_i_* request pulses, address, store data
// and size flags; DMEM_o_* read data, rvalid/wdone pulses, busy, misalign, overlap_err.
// Optional macro DMEM_RAND_DELAY_EN adds 0..3 extra wait cycles taken from a 16-bit LFSR.
module dmem_pulse_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_i_raddr_change,
  input  logic        MEM_i_waddr_change,
  input  logic [31:0] MEM_i_ALU_ALUout,
  input  logic [31:0] MEM_i_rs2_data,
  input  logic        MEM_i_mem_byte,
  input  logic        MEM_i_mem_half,
  input  logic        MEM_i_mem_word,
  input  logic        MEM_i_mem_byte_u,
  input  logic        MEM_i_mem_half_u,
  output logic [31:0] DMEM_o_rdata,
  output logic        DMEM_o_rvalid,
  output logic        DMEM_o_wdone,
  output logic        DMEM_o_busy,
  output logic        DMEM_o_misalign,
  output logic        DMEM_o_overlap_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_load;
  logic [31:0]   addr_q, data_q;
  logic [4:0]    sz_q;   // {half_u, byte_u, word, half, byte}
  logic          wr_q, mis_q, pend_q, err_q;
  logic          start, start_wr, use_in, set_pend, clr_pend, ovl;
  logic          any_pulse, mis_in;
  logic [31:0]   mem [DEPTH_WORDS];

`ifdef DMEM_RAND_DELAY_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign cnt_load = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
`else
  assign cnt_load = CW'(LATENCY - 1);
`endif

  assign any_pulse = MEM_i_raddr_change | MEM_i_waddr_change;
  assign mis_in    = ((MEM_i_mem_half | MEM_i_mem_half_u) & MEM_i_ALU_ALUout[0]) |
                     (MEM_i_mem_word & (MEM_i_ALU_ALUout[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    start_wr  = 1'b0;
    use_in    = 1'b0;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    ovl       = 1'b0;
    case (state)
      IDLE: begin
        if (pend_q) begin
          // Held read of a combined pulse: reuses the address and flags already latched.
          start    = 1'b1;
          clr_pend = 1'b1;
          ovl      = any_pulse;
        end else if (MEM_i_waddr_change) begin
          start    = 1'b1;
          start_wr = 1'b1;
          use_in   = 1'b1;
          set_pend = MEM_i_raddr_change;
        end else if (MEM_i_raddr_change) begin
          start  = 1'b1;
          use_in = 1'b1;
        end
        if (start) begin
          if (cnt_load == '0) state_nxt = RESP;
          else                state_nxt = start_wr ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        ovl = any_pulse;
        // Counter is never 0 here; leaving on 1 lands RESP exactly LATENCY cycles after the pulse.
        if (cnt <= CW'(1)) state_nxt = RESP;
      end
      RESP: begin
        ovl       = any_pulse;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      sz_q   <= '0;
      wr_q   <= 1'b0;
      mis_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (start) begin
        cnt  <= cnt_load;
        wr_q <= start_wr;
        if (use_in) begin
          addr_q <= MEM_i_ALU_ALUout;
          data_q <= MEM_i_rs2_data;
          sz_q   <= {MEM_i_mem_half_u, MEM_i_mem_byte_u, MEM_i_mem_word,
                     MEM_i_mem_half, MEM_i_mem_byte};
          mis_q  <= mis_in;
        end
      end else if (state == RD_WAIT || state == WR_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (set_pend)      pend_q <= 1'b1;
      else if (clr_pend) pend_q <= 1'b0;
      if (ovl) err_q <= 1'b1;
    end
  end

  // Upper address bits wrap away.
  logic          unused_addr_hi;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  assign unused_addr_hi = ^addr_q[31:AW+2];
  assign idx            = addr_q[AW+1:2];
  assign lane           = addr_q[1:0];

  // Store lane enables and replicated data.
  logic [3:0]  be;
  logic [31:0] wdat;
  always_comb begin
    be   = 4'b0000;
    wdat = data_q;
    if (sz_q[0] | sz_q[3]) begin
      be   = 4'b0001 << lane;
      wdat = {4{data_q[7:0]}};
    end else if (sz_q[1] | sz_q[4]) begin
      be   = lane[1] ? 4'b1100 : 4'b0011;
      wdat = {2{data_q[15:0]}};
    end else if (sz_q[2]) begin
      be   = 4'b1111;
    end
  end

  // The array is not reset; a reset in the RESP cycle suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && wr_q && !mis_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  logic [31:0] word_rd, shifted, ext;
  logic [15:0] half_sel;
  assign word_rd  = mem[idx];
  assign shifted  = word_rd >> {lane, 3'b000};
  assign half_sel = lane[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    ext = '0;
    if      (sz_q[0]) ext = {{24{shifted[7]}}, shifted[7:0]};
    else if (sz_q[3]) ext = {24'h0, shifted[7:0]};
    else if (sz_q[1]) ext = {{16{half_sel[15]}}, half_sel};
    else if (sz_q[4]) ext = {16'h0, half_sel};
    else if (sz_q[2]) ext = word_rd;
  end

  logic resp;
  assign resp               = !rst && state == RESP;
  assign DMEM_o_rvalid      = resp && !wr_q;
  assign DMEM_o_wdone       = resp && wr_q;
  assign DMEM_o_misalign    = resp && mis_q;
  assign DMEM_o_rdata       = (DMEM_o_rvalid && !mis_q) ? ext : 32'h0;
  // Pending read keeps the stage stalled across the write's RESP cycle.
  assign DMEM_o_busy        = !rst && (state == RD_WAIT || state == WR_WAIT || pend_q || any_pulse);
  assign DMEM_o_overlap_err = !rst && err_q;

endmodule
